// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: address/level sizing helpers and flag polarity,
// common to every FIFO variant in the library.
package fifo_pkg;

  localparam logic FLAG_ON  = 1'b1;
  localparam logic FLAG_OFF = 1'b0;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned width;
    width = 0;
    for (int unsigned i = 1; i < value; i = i << 1) begin
      width++;
    end
    return width;
  endfunction

  // Level counters need one extra bit so that "exactly DEPTH" is representable.
  function automatic int unsigned level_width(input int unsigned depth);
    return log2_ceil(depth) + 1;
  endfunction

endpackage

// File: rtl/sdp_ram_reg.sv
// Simple dual-port RAM: one write port, one registered read port with
// read-enable. The read register holds its value while re_i is low.
module sdp_ram_reg
  import fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 256,
  localparam int unsigned AW         = log2_ceil(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sdp_fwft.sv
// First-word-fall-through FIFO over a registered-read SDP RAM, with a
// two-stage prefetch (RAM read register, output register), level and flags.
module fifo_sdp_fwft
  import fifo_pkg::*;
#(
  parameter  int unsigned DEPTH      = 256,
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned AW         = log2_ceil(DEPTH),
  localparam int unsigned LW         = level_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic [LW-1:0]         af_level,
  input  logic [LW-1:0]         ae_level,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic                  reset_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  s1_valid_q, s1_valid_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [LW-1:0]         ram_cnt;
  logic                  accept;
  logic                  pop;
  logic                  out_load;
  logic                  ram_re;

  sdp_ram_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (accept),
    .waddr_i(wr_ptr_q),
    .wdata_i(in_data),
    .re_i   (ram_re),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    in_ready = !reset_q && !flush && (level_q != FULL_LEVEL);
    accept   = in_valid && in_ready;
    pop      = out_valid_q && out_ready && !flush;

    // Words still sitting in RAM: total held minus those already prefetched.
    // A read is only issued when the read register will be free next edge,
    // so that register doubles as the skid stage.
    ram_cnt  = level_q - LW'(s1_valid_q) - LW'(out_valid_q);
    out_load = s1_valid_q && (!out_valid_q || pop);
    ram_re   = (ram_cnt != '0) && (!s1_valid_q || out_load) && !flush;

    wr_ptr_d    = wr_ptr_q + AW'(accept);
    rd_ptr_d    = rd_ptr_q + AW'(ram_re);
    s1_valid_d  = ram_re || (s1_valid_q && !out_load);
    out_valid_d = out_load || (out_valid_q && !pop);
    out_data_d  = out_load ? ram_rdata : out_data_q;

    level_d = level_q;
    if (accept && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !accept) begin
      level_d = level_q - LW'(1);
    end

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reset_q     <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      reset_q     <= 1'b0;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    out_valid    = out_valid_q;
    out_data     = out_data_q;
    level        = level_q;
    almost_full  = (level_q >= af_level) ? FLAG_ON : FLAG_OFF;
    almost_empty = (level_q <= ae_level) ? FLAG_ON : FLAG_OFF;
  end

endmodule

// File: tb/tb_fifo_sdp_fwft.sv
// Self-checking bench for fifo_sdp_fwft: queue-based reference model with
// per-word visibility times, directed scenarios plus randomized backpressure.
`timescale 1ns/1ps
module tb_fifo_sdp_fwft;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned LW    = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid, almost_full, almost_empty;
  logic [DW-1:0] in_data, out_data;
  logic [LW-1:0] af_level, ae_level, level;

  fifo_sdp_fwft #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .af_level    (af_level),
    .ae_level    (ae_level),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  // Model: each held word carries the edge count after which it may be shown.
  typedef struct {
    logic [DW-1:0] d;
    int unsigned   rdy;
  } ent_t;

  ent_t        mq[$];
  int unsigned edge_n  = 0;
  bit          rst_m   = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  function automatic bit exp_in_ready();
    return !rst_m && !flush && (mq.size() != DEPTH);
  endfunction

  function automatic bit exp_out_valid();
    return (mq.size() != 0) && (edge_n >= mq[0].rdy);
  endfunction

  // Advance one clock edge and update the model; returns 1ns after the edge.
  task automatic tick();
    bit   acc, pp;
    ent_t e;
    acc = in_valid && exp_in_ready();
    pp  = exp_out_valid() && out_ready && !flush;
    e.d   = in_data;
    @(posedge clk);
    edge_n++;
    if (reset || flush) begin
      mq.delete();
    end else begin
      if (pp) begin
        void'(mq.pop_front());
        if (mq.size() != 0 && mq[0].rdy < edge_n) mq[0].rdy = edge_n;
      end
      if (acc) begin
        e.rdy = edge_n + 2;
        mq.push_back(e);
      end
    end
    rst_m = reset;
    #1;
  endtask

  task automatic drain();
    int unsigned guard;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard     = 0;
    while (mq.size() != 0 && guard < 4 * DEPTH + 8) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full_af14: got %b want 0", almost_full); end
    af_level = '0;
    #1;
    n_tests++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL reset_almost_full_af0: got %b want 1", almost_full); end
    af_level = LW'(14);
    reset = 1'b0;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    ae_level = LW'(2);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e0_valid: got %b want 0", out_valid); end
    n_tests++; if (level !== LW'(1)) begin n_fail++; $display("FAIL single_e0_level: got %0d want 1", level); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_e1_valid: got %b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_e2_valid: got %b want 1", out_valid); end
    n_tests++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", out_data); end
    n_tests++; if (level !== LW'(1)) begin n_fail++; $display("FAIL single_level: got %0d want 1", level); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL single_almost_empty: got %b want 1", almost_empty); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL single_pop_level: got %0d want 0", level); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_fill();
    int unsigned acc_dut, k, guard;
    af_level  = LW'(14);
    out_ready = 1'b0;
    acc_dut   = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      #1;
      n_tests++; if (in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want %b", i, in_ready, exp_in_ready()); end
      if (in_ready === 1'b1) acc_dut++;
      tick();
      n_tests++; if (level !== LW'(mq.size())) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, mq.size()); end
      n_tests++; if (almost_full !== (mq.size() >= 14)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, mq.size() >= 14); end
    end
    in_valid = 1'b0;
    n_tests++; if (acc_dut != DEPTH) begin n_fail++; $display("FAIL fill_accept_count: got %0d want %0d", acc_dut, DEPTH); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
    n_tests++; if (level !== LW'(DEPTH)) begin n_fail++; $display("FAIL full_level: got %0d want %0d", level, DEPTH); end
    n_tests++; if (out_data !== 8'h00 || out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_first: got %h/%b want 00/1", out_data, out_valid); end
    out_ready = 1'b1;
    tick();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unfull_in_ready: got %b want 1", in_ready); end
    k = 1;
    guard = 0;
    while (k < DEPTH && guard < 40) begin
      if (out_valid === 1'b1) begin
        n_tests++; if (out_data !== DW'(k)) begin n_fail++; $display("FAIL drain_order[%0d]: got %h want %h", k, out_data, DW'(k)); end
        k++;
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    n_tests++; if (k != DEPTH) begin n_fail++; $display("FAIL drain_timeout: got %0d words want %0d", k, DEPTH); end
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL drain_level: got %0d want 0", level); end
  endtask

  task automatic test_streaming();
    int unsigned lvl0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      in_data = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    lvl0      = mq.size();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      in_data = DW'($urandom);
      #1;
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
      n_tests++; if (mq.size() != 0 && out_data !== mq[0].d) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, mq[0].d); end
      n_tests++; if (level !== LW'(lvl0)) begin n_fail++; $display("FAIL stream_level[%0d]: got %0d want %0d", i, level, lvl0); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    int unsigned accepted, cyc;
    accepted = 0;
    cyc      = 0;
    while (accepted < 10000 && cyc < 60000) begin
      if (cyc % 64 == 0) begin
        af_level = LW'($urandom_range(0, DEPTH));
        ae_level = LW'($urandom_range(0, DEPTH));
      end
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      flush     = ($urandom_range(0, 399) == 0);
      #1;
      n_tests++; if (level !== LW'(mq.size())) begin n_fail++; $display("FAIL rand_level[%0d]: got %0d want %0d", cyc, level, mq.size()); end
      n_tests++; if (out_valid !== exp_out_valid()) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b want %b", cyc, out_valid, exp_out_valid()); end
      if (exp_out_valid()) begin
        n_tests++; if (out_data !== mq[0].d) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", cyc, out_data, mq[0].d); end
      end
      n_tests++; if (in_ready !== exp_in_ready()) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b want %b", cyc, in_ready, exp_in_ready()); end
      n_tests++; if (almost_full !== (mq.size() >= int'(af_level))) begin n_fail++; $display("FAIL rand_almost_full[%0d]: got %b want %b", cyc, almost_full, mq.size() >= int'(af_level)); end
      n_tests++; if (almost_empty !== (mq.size() <= int'(ae_level))) begin n_fail++; $display("FAIL rand_almost_empty[%0d]: got %b want %b", cyc, almost_empty, mq.size() <= int'(ae_level)); end
      if (in_valid && exp_in_ready()) accepted++;
      tick();
      cyc++;
    end
    flush = 1'b0;
    n_tests++; if (accepted < 10000) begin n_fail++; $display("FAIL rand_timeout: got %0d words want 10000", accepted); end
    af_level = LW'(14);
    ae_level = LW'(2);
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int unsigned i = 0; i < 9; i++) begin
      in_data = DW'(8'h10 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    n_tests++; if (level !== LW'(9)) begin n_fail++; $display("FAIL flush_pre_level: got %0d want 9", level); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", level); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_post_in_ready: got %b want 1", in_ready); end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_new_e0: got %b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_new_e1: got %b want 0", out_valid); end
    tick();
    n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin n_fail++; $display("FAIL flush_new_word: got %b/%h want 1/3c", out_valid, out_data); end
    n_tests++; if (level !== LW'(1)) begin n_fail++; $display("FAIL flush_new_level: got %0d want 1", level); end
    drain();
  endtask

  task automatic test_thresh_reset();
    ae_level  = LW'(4);
    af_level  = LW'(14);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      in_data = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    n_tests++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL thr_ae4: got %b want 0", almost_empty); end
    ae_level = LW'(6);
    #1;
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL thr_ae6: got %b want 1", almost_empty); end
    reset = 1'b1;
    tick();
    n_tests++; if (level !== '0) begin n_fail++; $display("FAIL rst2_level: got %0d want 0", level); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst2_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rst2_out_data: got %h want 00", out_data); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst2_in_ready: got %b want 0", in_ready); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst2_almost_empty: got %b want 1", almost_empty); end
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL rst2_almost_full: got %b want 0", almost_full); end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    af_level  = LW'(14);
    ae_level  = LW'(2);
    test_reset();
    test_single();
    test_fill();
    test_streaming();
    test_random();
    test_flush();
    test_thresh_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
